captura_pin: RTL
================

Name: captura_pin

Overview:
Keypad front-end for the parking-gate controller. It converts individual keypad presses into the 8-bit `pin` word and the one-cycle `pin_validation` strobe consumed directly downstream by the gate state machine. It assembles two hex digits, guards against malformed entries and stale partial entries, and presents a stable `pin` value together with a single validation pulse per completed entry.

Parameters:
TIMEOUT_CYCLES, 1000, consecutive event-free cycles allowed while an entry is partial before it is discarded (>=2)
TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
key_digit  input  1  level, high while a digit key is held; synchronous to clock
key_code  input  4  hex digit 0x0-0xF, valid whenever key_digit is high
key_enter  input  1  level, enter key held
key_clear  input  1  level, clear key held
pin  output  8  last submitted PIN, {first digit, second digit}
pin_validation  output  1  one-cycle strobe marking a new pin
entry_error  output  1  one-cycle strobe on a malformed or timed-out entry
digit_count  output  2  digits currently buffered (0, 1 or 2)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; pin=0, pin_validation=0, entry_error=0, digit_count=0.
  - Digit buffer and timeout counter cleared.
  - Previous-value registers of key_digit, key_enter and key_clear set to 1. A key held through reset release therefore produces no event.
- Event detection: ev_x = x & ~prev_x, where prev_x is x registered each edge. Each press yields exactly one event regardless of hold length.
- Priority when events coincide in one cycle: clear > enter > digit. Lower-priority events in that cycle are dropped.
- All outputs are registered. A response to an event sampled at edge k appears from edge k until edge k+1. Strobes are exactly 1 cycle wide.
- States:
  - IDLE (digit_count=0): ev_digit stores key_code in hi nibble -> ONE. ev_enter -> entry_error pulse, stay IDLE. ev_clear -> stay IDLE, no error.
  - ONE (digit_count=1): ev_digit stores key_code in lo nibble -> TWO. ev_enter -> entry_error, buffer cleared -> IDLE. ev_clear -> IDLE, no error.
  - TWO (digit_count=2): ev_enter -> pin<=buffer, pin_validation=1, buffer cleared -> IDLE. ev_digit -> entry_error, digit ignored, stay TWO. ev_clear -> IDLE.
- pin:
  - Changes only on a successful enter; holds otherwise, including across clear, error and timeout.
  - pin_validation and the new pin value appear in the same cycle.
  - Submitting an identical pin twice still yields two strobes.
- Timeout:
  - Counter cleared on every accepted event and whenever in IDLE.
  - Increments each cycle in ONE/TWO with no event.
  - When it reaches TIMEOUT_CYCLES: entry_error pulse, buffer cleared -> IDLE, pin unchanged.
  - An event in the same cycle as expiry wins; the counter clears and there is no timeout.
- digit_count reflects the state after the edge, e.g. reads 1 the cycle after the first digit.
- Reset asserted mid-entry: immediate IDLE, buffer lost, no strobe issued, pin forced to 0.
- No combinational path from any input to any output.

Test Plan:
- Reset release with key_enter held high -> no entry_error, no pin_validation. Release then re-press enter -> entry_error for 1 cycle.
- Press 3, release, press D, release, press enter -> pin=8'h3D and pin_validation high exactly 1 cycle at the edge after enter; digit_count 0->1->2->0.
- Enter after only digit 5 -> entry_error 1 cycle, pin_validation stays 0, pin retains previous 8'h3D, state IDLE.
- Digits 1,2,7 then enter -> entry_error on the 7, then pin=8'h12 with pin_validation. key_clear and key_enter rising in the same cycle in TWO -> IDLE, no strobes.
- TIMEOUT_CYCLES=8; press digit 4 then idle -> entry_error exactly 8 cycles after the digit event, digit_count=0. A digit press on cycle 8 instead -> no error, digit_count=2.
- Assert reset while in TWO holding 8'hAB -> pin=0, digit_count=0 asynchronously. Enter after release -> entry_error, no validation.

Source files
------------

// File: rtl/captura_pin.sv
// captura_pin: keypad front-end that assembles two hex digits into an 8-bit
// PIN. It issues one validation strobe per completed entry, and one error
// strobe for a malformed entry or for a partial entry that was left idle.
module captura_pin #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_W           = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_digit,
    input  logic [3:0] key_code,
    input  logic       key_enter,
    input  logic       key_clear,
    output logic [7:0] pin,
    output logic       pin_validation,
    output logic       entry_error,
    output logic [1:0] digit_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_buf, w_buf_nxt;
    logic [7:0]      r_pin, w_pin_nxt;
    logic            r_val, w_val_nxt;
    logic            r_err, w_err_nxt;
    logic [TO_W-1:0] r_cnt, w_cnt_nxt;
    logic            r_prev_dig, r_prev_ent, r_prev_clr;
    logic            w_ev_dig, w_ev_ent, w_ev_clr, w_expire;

    // Rising-edge detection with priority clear > enter > digit. The previous
    // values reset to 1, so a key held through reset release gives no event.
    assign w_ev_clr = key_clear & ~r_prev_clr;
    assign w_ev_ent = key_enter & ~r_prev_ent & ~w_ev_clr;
    assign w_ev_dig = key_digit & ~r_prev_dig & ~w_ev_clr & ~w_ev_ent;
    // The partial entry expires on the cycle the idle count reaches TIMEOUT_CYCLES.
    assign w_expire = (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Register the previous key levels for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev_dig <= 1'b1;
            r_prev_ent <= 1'b1;
            r_prev_clr <= 1'b1;
        end else begin
            r_prev_dig <= key_digit;
            r_prev_ent <= key_enter;
            r_prev_clr <= key_clear;
        end
    end

    // State, buffer, timeout counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_buf   <= 8'h00;
            r_pin   <= 8'h00;
            r_val   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_pin   <= w_pin_nxt;
            r_val   <= w_val_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and next-output logic. The counter clears by default and
    // advances only in ONE or TWO when no event arrives.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_pin_nxt   = r_pin;
        w_val_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = '0;
        case (r_state)
            IDLE: begin
                w_buf_nxt = 8'h00;
                if (w_ev_dig) begin
                    w_buf_nxt   = {key_code, 4'h0};
                    w_state_nxt = ONE;
                end else if (w_ev_ent) begin
                    w_err_nxt = 1'b1;
                end
            end
            ONE: begin
                if (w_ev_clr) begin
                    w_buf_nxt   = 8'h00;
                    w_state_nxt = IDLE;
                end else if (w_ev_ent) begin
                    w_err_nxt   = 1'b1;
                    w_buf_nxt   = 8'h00;
                    w_state_nxt = IDLE;
                end else if (w_ev_dig) begin
                    w_buf_nxt   = {r_buf[7:4], key_code};
                    w_state_nxt = TWO;
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_buf_nxt   = 8'h00;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
            end
            TWO: begin
                if (w_ev_clr) begin
                    w_buf_nxt   = 8'h00;
                    w_state_nxt = IDLE;
                end else if (w_ev_ent) begin
                    w_pin_nxt   = r_buf;
                    w_val_nxt   = 1'b1;
                    w_buf_nxt   = 8'h00;
                    w_state_nxt = IDLE;
                end else if (w_ev_dig) begin
                    // A third digit is rejected; the two buffered digits are kept.
                    w_err_nxt = 1'b1;
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_buf_nxt   = 8'h00;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
            end
            default: begin
                w_buf_nxt   = 8'h00;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Decode digit_count from the state register.
    always_comb begin
        case (r_state)
            ONE:     digit_count = 2'd1;
            TWO:     digit_count = 2'd2;
            default: digit_count = 2'd0;
        endcase
    end

    assign pin            = r_pin;
    assign pin_validation = r_val;
    assign entry_error    = r_err;

endmodule
